cmd_ack_binary_tree_8_1_seq: RTL and testbench

- Return-path partner of the 1-to-8 pipelined command distribution tree in the non-hierarchical 8x8 crossbar.
- Gathers eight single-bit acknowledge/status bits, one per crossbar output port, through a registered binary merge tree into one 8-bit word.
- A small collection FSM accumulates acks against an expected mask, then reports completion or timeout to the command issuer.

---
 rtl/cmd_ack_binary_tree_8_1_seq_pkg.sv | 19 +
 rtl/cmd_ack_binary_tree_8_1_seq_tree.sv | 38 +++
 rtl/cmd_ack_binary_tree_8_1_seq.sv | 128 ++++++++++++
 tb/tb_cmd_ack_binary_tree_8_1_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_ack_binary_tree_8_1_seq_pkg.sv
// Shared crossbar definitions for the acknowledge return path.
// Covers the port count, the collection FSM encoding and the default timeout.
package cmd_ack_binary_tree_8_1_seq_pkg;

    localparam int NUM_PORT               = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } ack_state_e;

    typedef enum logic {
        KIND_DONE    = 1'b0,
        KIND_TIMEOUT = 1'b1
    } report_kind_e;

endpackage

// File: rtl/cmd_ack_binary_tree_8_1_seq_tree.sv
// Registered binary merge tree: eight ack leaves -> one word, fixed 3-cycle latency.
// Only the leaf level honours i_en; the upper levels always shift.
module ack_merge_tree_seq
    import cmd_ack_binary_tree_8_1_seq_pkg::*;
#(
    parameter int NUM_INPUT_DATA = NUM_PORT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [NUM_INPUT_DATA-1:0] i_ack,
    output logic [NUM_INPUT_DATA-1:0] gathered
);

    localparam int NUM_LEVEL = $clog2(NUM_INPUT_DATA);

    // Pairwise concatenation {upper, lower} keeps leaf order, so each level is
    // a full-width register whose 2/4/8-bit slices are that level's nodes.
    logic [NUM_INPUT_DATA-1:0] level_q [NUM_LEVEL];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int l = 0; l < NUM_LEVEL; l++) begin
                level_q[l] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_INPUT_DATA / 2; j++) begin
                level_q[0][2*j +: 2] <= i_en ? {i_ack[2*j+1], i_ack[2*j]} : 2'b00;
            end
            for (int l = 1; l < NUM_LEVEL; l++) begin
                level_q[l] <= level_q[l-1];
            end
        end
    end

    assign gathered = level_q[NUM_LEVEL-1];

endmodule

// File: rtl/cmd_ack_binary_tree_8_1_seq.sv
// Ack collector: merge tree plus an IDLE/COLLECT/REPORT FSM reporting done or timeout.
// Optional CMD_ACK_UNEXP_ERR_EN adds o_unexp_err for acks outside the expected mask.
module cmd_ack_binary_tree_8_1_seq
    import cmd_ack_binary_tree_8_1_seq_pkg::*;
#(
    parameter int NUM_INPUT_DATA = NUM_PORT,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_ack_0,
    input  logic                i_ack_1,
    input  logic                i_ack_2,
    input  logic                i_ack_3,
    input  logic                i_ack_4,
    input  logic                i_ack_5,
    input  logic                i_ack_6,
    input  logic                i_ack_7,
    input  logic                i_start,
    input  logic [NUM_PORT-1:0] i_expect,
    output logic [NUM_PORT-1:0] o_status,
    output logic                o_done,
    output logic                o_timeout,
    output logic                o_busy,
`ifdef CMD_ACK_UNEXP_ERR_EN
    output logic                o_unexp_err,
`endif
    output logic [1:0]          o_dbg_state
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    ack_state_e          state, state_next;
    report_kind_e        kind, kind_next;
    logic [NUM_PORT-1:0] gathered;
    logic [NUM_PORT-1:0] expect_reg;
    logic [NUM_PORT-1:0] sticky, sticky_next;
    logic [NUM_PORT-1:0] status_q;
    logic [TIMER_W-1:0]  timer;
    logic                all_seen;
    logic                timer_last;

    ack_merge_tree_seq #(
        .NUM_INPUT_DATA(NUM_INPUT_DATA)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .i_en     (i_en),
        .i_ack    ({i_ack_7, i_ack_6, i_ack_5, i_ack_4, i_ack_3, i_ack_2, i_ack_1, i_ack_0}),
        .gathered (gathered)
    );

    // Done looks at this cycle's acks too, so a final ack is not lost to the timer.
    always_comb begin
        sticky_next = sticky | (gathered & expect_reg);
        all_seen    = (sticky_next == expect_reg);
        timer_last  = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
        state_next  = state;
        kind_next   = kind;
        case (state)
            ST_IDLE: begin
                if (i_start) state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (all_seen) begin
                    state_next = ST_REPORT;
                    kind_next  = KIND_DONE;
                end else if (timer_last) begin
                    state_next = ST_REPORT;
                    kind_next  = KIND_TIMEOUT;
                end
            end
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            kind  <= KIND_DONE;
        end else begin
            state <= state_next;
            kind  <= kind_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            expect_reg <= '0;
            sticky     <= '0;
            timer      <= '0;
            status_q   <= '0;
        end else if (state == ST_IDLE && i_start) begin
            expect_reg <= i_expect;
            sticky     <= '0;
            timer      <= '0;
        end else if (state == ST_COLLECT) begin
            sticky <= sticky_next;
            timer  <= timer + TIMER_W'(1);
            if (state_next == ST_REPORT) status_q <= sticky_next;
        end
    end

`ifdef CMD_ACK_UNEXP_ERR_EN
    logic unexp_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            unexp_q <= 1'b0;
        end else if (state == ST_IDLE && i_start) begin
            unexp_q <= 1'b0;
        end else if (state == ST_COLLECT) begin
            unexp_q <= unexp_q | (|(gathered & ~expect_reg));
        end
    end

    assign o_unexp_err = (state == ST_REPORT) && unexp_q;
`endif

    assign o_status    = status_q;
    assign o_done      = (state == ST_REPORT) && (kind == KIND_DONE);
    assign o_timeout   = (state == ST_REPORT) && (kind == KIND_TIMEOUT);
    assign o_busy      = (state != ST_IDLE);
    assign o_dbg_state = state;

endmodule

// File: tb/tb_cmd_ack_binary_tree_8_1_seq.sv
// Bench for cmd_ack_binary_tree_8_1_seq: scheduled ack stimulus, queue scoreboard, report monitor.
// Honours CMD_ACK_UNEXP_ERR_EN when defined.
module tb_cmd_ack_binary_tree_8_1_seq;

    localparam int TO        = 64;
    localparam int SCHED_LEN = TO;
    localparam int MAX_CYC   = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic       i_start;
    logic [7:0] i_expect;
    logic [7:0] ack_vec;
    logic [7:0] o_status;
    logic       o_done;
    logic       o_timeout;
    logic       o_busy;
    logic [1:0] o_dbg_state;
`ifdef CMD_ACK_UNEXP_ERR_EN
    logic       o_unexp_err;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          checking = 1'b0;
    logic [7:0]  hist [MAX_CYC];
    logic [7:0]  sched_ack [SCHED_LEN];
    logic        sched_en  [SCHED_LEN];
    logic [31:0] exp_q [$];
    logic [31:0] mon_e;
    logic [7:0]  last_status = 8'h00;

    cmd_ack_binary_tree_8_1_seq #(
        .NUM_INPUT_DATA(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_ack_0     (ack_vec[0]),
        .i_ack_1     (ack_vec[1]),
        .i_ack_2     (ack_vec[2]),
        .i_ack_3     (ack_vec[3]),
        .i_ack_4     (ack_vec[4]),
        .i_ack_5     (ack_vec[5]),
        .i_ack_6     (ack_vec[6]),
        .i_ack_7     (ack_vec[7]),
        .i_start     (i_start),
        .i_expect    (i_expect),
        .o_status    (o_status),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_busy      (o_busy),
`ifdef CMD_ACK_UNEXP_ERR_EN
        .o_unexp_err (o_unexp_err),
`endif
        .o_dbg_state (o_dbg_state)
    );

    // Clock and cycle/history bookkeeping: hist[n] is the gated leaf word seen at edge n.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            hist[cyc % MAX_CYC] = 8'h00;
            if (cyc >= 1) hist[(cyc - 1) % MAX_CYC] = 8'h00;
            if (cyc >= 2) hist[(cyc - 2) % MAX_CYC] = 8'h00;
            last_status = 8'h00;
        end else begin
            hist[cyc % MAX_CYC] = i_en ? ack_vec : 8'h00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Monitor: tree latency every cycle, and each report against the scoreboard.
    always @(negedge clk) begin
        if (checking) begin
            if (cyc >= 2) check("gathered", {24'd0, dut.u_tree.gathered}, {24'd0, hist[(cyc - 2) % MAX_CYC]});
            if (o_done || o_timeout) begin
                if (exp_q.size() == 0) begin
                    check("spurious_report", {30'd0, o_timeout, o_done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("report_cycle", cyc, {16'd0, mon_e[31:16]});
                    check("report_kind", {30'd0, o_timeout, o_done}, mon_e[8] ? 32'd2 : 32'd1);
                    check("report_status", {24'd0, o_status}, {24'd0, mon_e[7:0]});
                    check("busy_in_report", {31'd0, o_busy}, 32'd1);
                    check("state_in_report", {30'd0, o_dbg_state}, 32'd2);
`ifdef CMD_ACK_UNEXP_ERR_EN
                    check("unexp_err", {31'd0, o_unexp_err}, {31'd0, mon_e[9]});
`endif
                    last_status = mon_e[7:0];
                end
            end else begin
                check("status_hold", {24'd0, o_status}, {24'd0, last_status});
            end
        end
    end

    task automatic clear_sched();
        for (int k = 0; k < SCHED_LEN; k++) begin
            sched_ack[k] = 8'h00;
            sched_en[k]  = 1'b1;
        end
    endtask

    // Reference: collection cycle i (1-based) sees the leaf word driven i-3 cycles
    // after the start sample; acks stick, done beats timeout on cycle TO.
    task automatic run_txn(input logic [7:0] expv, input int hold);
        logic [7:0] acc;
        logic [7:0] e;
        logic       unexp;
        logic       is_to;
        int         i_end;
        int         s;
        acc = 8'h00; unexp = 1'b0; is_to = 1'b0; i_end = TO;
        for (int i = 1; i <= TO; i++) begin
            e = (i >= 3 && sched_en[i - 3]) ? sched_ack[i - 3] : 8'h00;
            acc   = acc | (e & expv);
            unexp = unexp | (|(e & ~expv));
            if (acc == expv) begin
                i_end = i;
                break;
            end
            if (i == TO) is_to = 1'b1;
        end
        @(negedge clk);
        i_start  = 1'b1;
        i_expect = expv;
        ack_vec  = sched_ack[0];
        i_en     = sched_en[0];
        s = cyc + 1;
        exp_q.push_back({16'(s + i_end), 6'd0, unexp, is_to, acc});
        for (int k = 1; k <= i_end; k++) begin
            @(negedge clk);
            i_start = (k <= hold);
            if (i_start) i_expect = 8'($urandom);
            ack_vec = (k < SCHED_LEN) ? sched_ack[k] : 8'h00;
            i_en    = (k < SCHED_LEN) ? sched_en[k] : 1'b1;
        end
        @(negedge clk);
        i_start = 1'b0;
        ack_vec = 8'h00;
        i_en    = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_after_report", {31'd0, o_busy}, 32'd0);
        if (exp_q.size() != 0) begin
            check("missing_report", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, {24'd0, o_status}, 32'd0);
        check({tag, "_flags"}, {29'd0, o_busy, o_timeout, o_done}, 32'd0);
        check({tag, "_state"}, {30'd0, o_dbg_state}, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < MAX_CYC; k++) hist[k] = 8'h00;
        rst = 1'b0; i_en = 1'b1; i_start = 1'b0; i_expect = 8'h00; ack_vec = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        checking = 1'b1;
        repeat (2) @(negedge clk);

        // Empty mask: done on the first collection cycle with zero status.
        clear_sched();
        run_txn(8'h00, 0);

        // Latency: single ack 3 pulse, nothing else -> timeout with bit 3 only.
        clear_sched();
        sched_ack[5] = 8'h08;
        run_txn(8'hFF, 0);

        // Full ack at staggered times, i_start held high throughout.
        clear_sched();
        sched_ack[1] = 8'h01; sched_ack[4] = 8'h04; sched_ack[9] = 8'h20; sched_ack[15] = 8'h80;
        run_txn(8'hA5, 40);

        // Timeout with only acks 0 and 1.
        clear_sched();
        sched_ack[2] = 8'h01; sched_ack[7] = 8'h02; sched_ack[20] = 8'h03;
        run_txn(8'h0F, 0);

        // Masking and enable gating, then the real ack.
        clear_sched();
        sched_ack[2] = 8'h40;
        sched_ack[5] = 8'h01; sched_en[5] = 1'b0;
        sched_ack[10] = 8'h01;
        run_txn(8'h01, 0);

        // Done on the very last timer cycle.
        clear_sched();
        sched_ack[TO - 3] = 8'h01;
        run_txn(8'h01, 0);

        // Reset mid-collection with acks in flight: no report, flushed tree.
        clear_sched();
        @(negedge clk); i_start = 1'b1; i_expect = 8'hFF; ack_vec = 8'h00;
        @(negedge clk); i_start = 1'b0;
        @(negedge clk);
        @(negedge clk); ack_vec = 8'hFF;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b1; ack_vec = 8'h00;
        sched_ack[5] = 8'hFF;
        run_txn(8'hFF, 0);

        // Randomized collections.
        for (int t = 0; t < 24; t++) begin
            int   r;
            logic [7:0] m;
            r = $urandom_range(0, 9);
            m = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            for (int k = 0; k < SCHED_LEN; k++) begin
                if (t % 3 == 0) sched_ack[k] = 8'($urandom & $urandom & $urandom & $urandom & $urandom);
                else            sched_ack[k] = 8'($urandom & $urandom & $urandom);
                sched_en[k] = ($urandom_range(0, 7) != 0);
            end
            run_txn(m, $urandom_range(0, 6));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule
